dsp_pipe_chain: RTL and testbench

//   Runtime-selectable register pipeline for DSP48A1-style datapath operands.

---
 rtl/dsp_pipe_chain.sv | 134 +++++++++++++
 tb/tb_dsp_pipe_chain.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_pipe_chain.sv
// Runtime-selectable register pipeline with flush, occupancy count and tap-change hold-off.
// Optional macro PIPE_PARITY_EN adds per-stage even parity and a registered parity_err output.
module dsp_pipe_chain #(
  parameter int WIDTH     = 18,
  parameter int MAX_DEPTH = 4,
  parameter int TAPW      = $clog2(MAX_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             flush,
  input  logic [TAPW-1:0]  tap,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [TAPW-1:0]  occupancy,
  output logic             busy
`ifdef PIPE_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  // Handshake: a word is consumed downstream on a clk edge with ce=1 while
  // dout_valid=1; there is no ready, the pipe never back-pressures.

  logic [WIDTH-1:0] r_data [1:MAX_DEPTH];
  logic [MAX_DEPTH:1] r_valid;
  logic [TAPW-1:0]    r_tap_q;
  logic [TAPW-1:0]    r_hold;

  logic [TAPW-1:0]  w_tap_eff;
  logic             w_tap_change;
  logic [WIDTH-1:0] w_tap_data;
  logic             w_tap_valid;
  logic [TAPW-1:0]  w_occ;

  assign w_tap_eff    = (32'(tap) > MAX_DEPTH) ? TAPW'(MAX_DEPTH) : tap;
  assign w_tap_change = (w_tap_eff != r_tap_q);

`ifdef PIPE_PARITY_EN
  logic [MAX_DEPTH:1] r_par;
  logic               r_parity_err;
  logic               w_tap_par;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= MAX_DEPTH; k++) r_data[k] <= '0;
      r_valid <= '0;
`ifdef PIPE_PARITY_EN
      r_par <= '0;
`endif
    end else if (ce) begin
      if (flush) begin
        for (int k = 1; k <= MAX_DEPTH; k++) r_data[k] <= '0;
        r_valid <= '0;
`ifdef PIPE_PARITY_EN
        r_par <= '0;
`endif
      end else begin
        r_data[1]  <= din;
        r_valid[1] <= din_valid;
`ifdef PIPE_PARITY_EN
        r_par[1]   <= ^din;
`endif
        for (int k = 2; k <= MAX_DEPTH; k++) begin
          r_data[k]  <= r_data[k-1];
          r_valid[k] <= r_valid[k-1];
`ifdef PIPE_PARITY_EN
          r_par[k]   <= r_par[k-1];
`endif
        end
      end
    end
  end

  // tap_q follows the tap every edge; a change reloads the hold-off, which
  // then only counts down on ce edges so stalls extend it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tap_q <= '0;
      r_hold  <= '0;
    end else begin
      r_tap_q <= w_tap_eff;
      if (w_tap_change) begin
        r_hold <= w_tap_eff;
      end else if (ce && (r_hold != '0)) begin
        r_hold <= r_hold - TAPW'(1);
      end
    end
  end

  always_comb begin
    w_tap_data  = din;
    w_tap_valid = din_valid;
    w_occ       = '0;
`ifdef PIPE_PARITY_EN
    w_tap_par   = 1'b0;
`endif
    for (int k = 1; k <= MAX_DEPTH; k++) begin
      if (w_tap_eff == TAPW'(k)) begin
        w_tap_data  = r_data[k];
        w_tap_valid = r_valid[k];
`ifdef PIPE_PARITY_EN
        w_tap_par   = r_par[k];
`endif
      end
      if ((TAPW'(k) <= w_tap_eff) && r_valid[k]) begin
        w_occ = w_occ + TAPW'(1);
      end
    end
  end

  // A change to tap 0 has nothing stale to hide, so it overrides any pending hold-off.
  assign busy       = w_tap_change ? (w_tap_eff != '0) : (r_hold != '0);
  assign dout       = w_tap_data;
  assign dout_valid = w_tap_valid & ~busy;
  assign occupancy  = w_occ;

`ifdef PIPE_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= (w_tap_eff != '0) && w_tap_valid && ((^w_tap_data) != w_tap_par);
    end
  end

  assign parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_dsp_pipe_chain.sv
// Self-checking bench for dsp_pipe_chain: directed scenarios plus randomized traffic
// compared against a history-of-launched-words reference model.
module tb_dsp_pipe_chain;
  localparam int W  = 18;
  localparam int D  = 4;
  localparam int TW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic          flush;
  logic [TW-1:0] tap;
  logic [W-1:0]  din;
  logic          din_valid;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic [TW-1:0] occupancy;
  logic          busy;
`ifdef PIPE_PARITY_EN
  logic          parity_err;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  // Model: m_data[j]/m_valid[j] is the word presented j+1 ce edges ago (flush/reset give zero words).
  logic [W-1:0] m_data[$];
  logic         m_valid[$];
  int           m_tap_q;
  int           m_hold;

  logic [W-1:0]  exp_dout;
  logic          exp_dv;
  logic [TW-1:0] exp_occ;
  logic          exp_busy;

  dsp_pipe_chain #(.WIDTH(W), .MAX_DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .flush      (flush),
    .tap        (tap),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .occupancy  (occupancy),
    .busy       (busy)
`ifdef PIPE_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic int tap_eff_of(input logic [TW-1:0] t);
    return (int'(t) > D) ? D : int'(t);
  endfunction

  task automatic model_reset();
    m_data.delete();
    m_valid.delete();
    for (int k = 0; k < D; k++) begin
      m_data.push_back('0);
      m_valid.push_back(1'b0);
    end
    m_tap_q = 0;
    m_hold  = 0;
  endtask

  task automatic model_tick();
    int te;
    te = tap_eff_of(tap);
    if (ce) begin
      if (flush) begin
        for (int k = 0; k < D; k++) begin
          m_data[k]  = '0;
          m_valid[k] = 1'b0;
        end
      end else begin
        m_data.push_front(din);
        m_valid.push_front(din_valid);
        void'(m_data.pop_back());
        void'(m_valid.pop_back());
      end
    end
    if (te != m_tap_q) m_hold = te;
    else if (ce && m_hold > 0) m_hold = m_hold - 1;
    m_tap_q = te;
  endtask

  task automatic model_expect();
    int te;
    int n;
    te = tap_eff_of(tap);
    if (te == 0) begin
      exp_dout = din;
      exp_dv   = din_valid;
    end else begin
      exp_dout = m_data[te-1];
      exp_dv   = m_valid[te-1];
    end
    exp_busy = (te != m_tap_q) ? (te != 0) : (m_hold != 0);
    if (exp_busy) exp_dv = 1'b0;
    n = 0;
    for (int k = 0; k < te; k++) if (m_valid[k]) n++;
    exp_occ = TW'(n);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (ce && !flush && din_valid) exp_q.push_back(din);
      model_tick();
    end
    #1;
  endtask

  task automatic settle();
    ce        = 1'b1;
    flush     = 1'b0;
    din_valid = 1'b0;
    repeat (D + 2) tick();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({dout, dout_valid, occupancy, busy} !== {W'(0), 1'b0, TW'(0), 1'b0}) begin
      errors++;
      $display("FAIL reset_state: dout=%h v=%b occ=%0d busy=%b, required 0/0/0/0", dout, dout_valid, occupancy, busy);
    end
    rst = 1'b0;
    ce = 1'b1;
    flush = 1'b0;
    tap = 3'd3;
    for (int i = 0; i < 6; i++) begin
      din = W'($urandom);
      din_valid = 1'b1;
      tick();
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({dout, occupancy} !== {W'(0), TW'(0)}) begin
      errors++;
      $display("FAIL reset_midstream: dout=%h occ=%0d, required 0/0", dout, occupancy);
    end
    tap = 3'd0;
    din = 18'h2A5A5;
    din_valid = 1'b1;
    #1;
    checks++;
    if (dout !== 18'h2A5A5) begin
      errors++;
      $display("FAIL reset_bypass_dout: got %h, required 2a5a5", dout);
    end
    checks++;
    if ({dout_valid, occupancy, busy} !== {1'b1, TW'(0), 1'b0}) begin
      errors++;
      $display("FAIL reset_bypass_flags: v=%b occ=%0d busy=%b, required 1/0/0", dout_valid, occupancy, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    @(negedge clk);
    model_expect();
    checks++;
    if ({dout, dout_valid, occupancy, busy} !== {exp_dout, exp_dv, exp_occ, exp_busy}) begin
      errors++;
      $display("FAIL reset_release: got %h/%b/%0d/%b, required %h/%b/%0d/%b",
               dout, dout_valid, occupancy, busy, exp_dout, exp_dv, exp_occ, exp_busy);
    end
  endtask

  task automatic test_latency();
    tap = 3'd4;
    settle();
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      din = (i < 5) ? W'(i + 1) : W'(0);
      din_valid = (i < 5);
      @(negedge clk);
      model_expect();
      checks++;
      if ({dout, dout_valid, occupancy, busy} !== {exp_dout, exp_dv, exp_occ, exp_busy}) begin
        errors++;
        $display("FAIL latency_model cyc %0d: got %h/%b/%0d/%b, required %h/%b/%0d/%b", i,
                 dout, dout_valid, occupancy, busy, exp_dout, exp_dv, exp_occ, exp_busy);
      end
      if (i == 3) begin
        checks++;
        if (dout_valid !== 1'b0) begin
          errors++;
          $display("FAIL latency_early: dout_valid=%b after 3 edges, required 0", dout_valid);
        end
      end
      if (i == 4) begin
        checks++;
        if ({dout, dout_valid} !== {W'(1), 1'b1}) begin
          errors++;
          $display("FAIL latency_4: dout=%h v=%b after 4 edges, required 00001/1", dout, dout_valid);
        end
      end
      if (dout_valid) begin
        checks++;
        if (exp_q.size() == 0 || dout !== exp_q[0]) begin
          errors++;
          $display("FAIL latency_order: dout=%h, required %h", dout, (exp_q.size() != 0) ? exp_q[0] : W'(0));
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      tick();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL latency_drain: %0d words never seen, required 0", exp_q.size());
    end
  endtask

  task automatic test_ce_stall();
    logic [W-1:0]  f_dout;
    logic [TW-1:0] f_occ;
    f_dout = '0;
    f_occ  = '0;
    tap = 3'd2;
    settle();
    exp_q.delete();
    for (int i = 0; i < 14; i++) begin
      ce = !(i >= 5 && i <= 7);
      din = W'(32'h100 + i);
      din_valid = 1'b1;
      @(negedge clk);
      model_expect();
      checks++;
      if ({dout, dout_valid, occupancy, busy} !== {exp_dout, exp_dv, exp_occ, exp_busy}) begin
        errors++;
        $display("FAIL stall_model cyc %0d: got %h/%b/%0d/%b, required %h/%b/%0d/%b", i,
                 dout, dout_valid, occupancy, busy, exp_dout, exp_dv, exp_occ, exp_busy);
      end
      if (i == 5) begin
        f_dout = dout;
        f_occ  = occupancy;
      end
      if (i == 6 || i == 7) begin
        checks++;
        if ({dout, occupancy} !== {f_dout, f_occ}) begin
          errors++;
          $display("FAIL stall_frozen cyc %0d: dout=%h occ=%0d, required %h/%0d", i, dout, occupancy, f_dout, f_occ);
        end
      end
      if (dout_valid && ce) begin
        checks++;
        if (exp_q.size() == 0 || dout !== exp_q[0]) begin
          errors++;
          $display("FAIL stall_order: dout=%h, required %h", dout, (exp_q.size() != 0) ? exp_q[0] : W'(0));
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      tick();
    end
    ce = 1'b1;
    checks++;
    if (exp_q.size() != 2) begin
      errors++;
      $display("FAIL stall_inflight: %0d words pending, required 2", exp_q.size());
    end
  endtask

  task automatic test_flush();
    tap = 3'd4;
    settle();
    for (int i = 0; i < 4; i++) begin
      din = W'($urandom);
      din_valid = 1'b1;
      tick();
    end
    @(negedge clk);
    checks++;
    if (occupancy !== TW'(4)) begin
      errors++;
      $display("FAIL flush_full: occ=%0d, required 4", occupancy);
    end
    ce = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ce = 1'b1;
    @(negedge clk);
    checks++;
    if (occupancy !== TW'(4)) begin
      errors++;
      $display("FAIL flush_ce_low: occ=%0d, required 4", occupancy);
    end
    flush = 1'b1;
    din = W'($urandom);
    din_valid = 1'b1;
    tick();
    flush = 1'b0;
    din_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({occupancy, dout_valid, dout} !== {TW'(0), 1'b0, W'(0)}) begin
      errors++;
      $display("FAIL flush_clear: occ=%0d v=%b dout=%h, required 0/0/0", occupancy, dout_valid, dout);
    end
    tap = 3'd1;
    #1;
    checks++;
    if (occupancy !== TW'(0)) begin
      errors++;
      $display("FAIL flush_no_capture: stage1 occ=%0d, required 0", occupancy);
    end
  endtask

  task automatic test_tap_change();
    int busy_cnt;
    tap = 3'd1;
    settle();
    ce = 1'b1;
    din_valid = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      tap = (pass == 0) ? 3'd3 : 3'd7;
      busy_cnt = 0;
      for (int i = 0; i < 8; i++) begin
        din = W'($urandom);
        @(negedge clk);
        model_expect();
        checks++;
        if ({dout, dout_valid, occupancy, busy} !== {exp_dout, exp_dv, exp_occ, exp_busy}) begin
          errors++;
          $display("FAIL tap_model pass %0d cyc %0d: got %h/%b/%0d/%b, required %h/%b/%0d/%b", pass, i,
                   dout, dout_valid, occupancy, busy, exp_dout, exp_dv, exp_occ, exp_busy);
        end
        if (busy === 1'b1) begin
          busy_cnt++;
          checks++;
          if (dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL tap_hold_valid: dout_valid=%b while busy, required 0", dout_valid);
          end
        end
        tick();
      end
      checks++;
      if (busy_cnt != ((pass == 0) ? 4 : 5)) begin
        errors++;
        $display("FAIL tap_busy_len pass %0d: busy cycles=%0d, required %0d", pass, busy_cnt, (pass == 0) ? 4 : 5);
      end
    end
    tap = 3'd4;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL tap_clamp_same: busy=%b going 7->4, required 0", busy);
    end
    tick();
    tap = 3'd0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL tap_zero: busy=%b going to tap 0, required 0", busy);
    end
    tick();
  endtask

  task automatic test_random();
    exp_q.delete();
    for (int i = 0; i < 400; i++) begin
      ce        = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      din       = W'($urandom);
      din_valid = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) == 0) tap = TW'($urandom_range(0, 7));
      @(negedge clk);
      model_expect();
      checks++;
      if ({dout, dout_valid, occupancy, busy} !== {exp_dout, exp_dv, exp_occ, exp_busy}) begin
        errors++;
        $display("FAIL random cyc %0d tap %0d: got %h/%b/%0d/%b, required %h/%b/%0d/%b", i, tap,
                 dout, dout_valid, occupancy, busy, exp_dout, exp_dv, exp_occ, exp_busy);
      end
      tick();
    end
    flush = 1'b0;
    ce = 1'b1;
  endtask

`ifdef PIPE_PARITY_EN
  task automatic test_parity();
    tap = 3'd2;
    settle();
    din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = W'($urandom);
      tick();
    end
    @(negedge clk);
    checks++;
    if (parity_err !== 1'b0) begin
      errors++;
      $display("FAIL parity_clean: parity_err=%b, required 0", parity_err);
    end
    dut.r_data[2][0] = ~dut.r_data[2][0];
    tick();
    @(negedge clk);
    checks++;
    if (parity_err !== 1'b1) begin
      errors++;
      $display("FAIL parity_set: parity_err=%b, required 1", parity_err);
    end
    tick();
    @(negedge clk);
    checks++;
    if (parity_err !== 1'b0) begin
      errors++;
      $display("FAIL parity_one_cycle: parity_err=%b, required 0", parity_err);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    ce = 1'b0;
    flush = 1'b0;
    tap = '0;
    din = '0;
    din_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    test_reset();
    test_latency();
    test_ce_stall();
    test_flush();
    test_tap_change();
    test_random();
`ifdef PIPE_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
